// File: rtl/apb_req_scheduler.sv
// apb_req_scheduler
// Two-requester APB master front end. Commands from two clients are arbitrated
// round-robin and each one runs as a single SETUP/ACCESS transfer to slave1
// (PADDR MSB = 0) or slave2 (PADDR MSB = 1). Completion comes back as a
// one-cycle pulse on the granted requester's rsp_done bit, with read data and
// a timeout flag. Only one transfer is ever outstanding.
module apb_req_scheduler #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_done,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                PSEL1,
  output logic                PSEL2,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY
);

  // Wait counter only has to reach TIMEOUT-1, the last ACCESS cycle allowed.
  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e              state_q;
  logic                rr_ptr_q;    // requester preferred when both are valid
  logic                gnt_q;       // owner of the transfer in flight
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic                psel1_q;
  logic                psel2_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [1:0]          done_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                gnt_d;
  logic                accept_d;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Round-robin grant and command mux; a command can only be taken in IDLE.
  always_comb begin
    gnt_d     = 1'b0;
    accept_d  = 1'b0;
    req_ready = 2'b00;
    if (state_q == S_IDLE && PRESETn) begin
      if (req_valid == 2'b11) begin
        gnt_d = rr_ptr_q;
      end else begin
        gnt_d = req_valid[1];
      end
      accept_d = |req_valid;
      if (accept_d) begin
        req_ready[gnt_d] = 1'b1;
      end
    end
    sel_write = gnt_d ? req_write[1] : req_write[0];
    sel_addr  = gnt_d ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_wdata = gnt_d ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  // Transfer FSM with registered bus and response outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 1'b0;
      gnt_q      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      psel1_q    <= 1'b0;
      psel2_q    <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // Response fields are single-cycle; they default back to zero.
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            gnt_q    <= gnt_d;
            rr_ptr_q <= ~gnt_d;
            write_q  <= sel_write;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            // Slave decode comes from the address MSB; the two selects are exclusive.
            psel1_q  <= ~sel_addr[ADDR_W-1];
            psel2_q  <= sel_addr[ADDR_W-1];
            pwrite_q <= sel_write;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY || (wait_cnt_q == CNT_LAST)) begin
            // Normal completion or timeout abort: release the bus and respond.
            psel1_q        <= 1'b0;
            psel2_q        <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            done_q[gnt_q]  <= 1'b1;
            err_q          <= ~PREADY;
            rdata_q        <= (PREADY && !write_q) ? PRDATA : '0;
            state_q        <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = addr_q;
  assign PWDATA    = wdata_q;
  assign rsp_done  = done_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Testbench for apb_req_scheduler: randomized requesters and APB slave,
// checked every cycle against a transaction-level timing model.
module tb_apb_req_scheduler;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic                PCLK = 1'b0;
  logic                PRESETn;
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_done;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                PSEL1;
  logic                PSEL2;
  logic                PENABLE;
  logic                PWRITE;
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;

  always #5 PCLK = ~PCLK;

  apb_req_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Requester-side pending commands.
  bit              pend [2];
  bit              pw   [2];
  logic [ADDR_W-1:0] pa [2];
  logic [DATA_W-1:0] pd [2];
  int              gen_pct [2];
  bit              allow_drop;

  // Reference model: one transfer in flight, described by its accept cycle and length.
  bit              m_busy;
  int              m_acc;
  int              m_len;
  bit              m_to;
  bit              m_g;
  bit              m_rr;
  bit              m_w;
  logic [ADDR_W-1:0] m_a;
  logic [DATA_W-1:0] m_d;
  logic [DATA_W-1:0] m_rd;
  logic [ADDR_W-1:0] last_a;
  logic [DATA_W-1:0] last_d;
  int              force_q [$];
  int              dut_grants [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic new_cmd(input int i);
    pend[i] = 1'b1;
    pw[i]   = 1'($urandom_range(1));
    pa[i]   = ADDR_W'($urandom);
    pd[i]   = DATA_W'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_psel1"},   PSEL1, 0);
    check_val({tag, "_psel2"},   PSEL2, 0);
    check_val({tag, "_penable"}, PENABLE, 0);
    check_val({tag, "_pwrite"},  PWRITE, 0);
    check_val({tag, "_paddr"},   PADDR, 0);
    check_val({tag, "_pwdata"},  PWDATA, 0);
    check_val({tag, "_ready"},   req_ready, 0);
    check_val({tag, "_done"},    rsp_done, 0);
    check_val({tag, "_err"},     rsp_err, 0);
    check_val({tag, "_rdata"},   rsp_rdata, 0);
  endtask

  // Compare DUT outputs for the current cycle against the model, then advance the model.
  task automatic check_cycle();
    bit g;
    int w;
    bit setup;
    if (req_ready != 2'b00) dut_grants.push_back(req_ready[1] ? 1 : 0);
    if (m_busy && cyc == m_acc + 2 + m_len) begin
      check_val("rsp_done", rsp_done, 32'(2'b01 << m_g));
      check_val("rsp_err", rsp_err, m_to);
      check_val("rsp_rdata", rsp_rdata, m_to ? 0 : m_rd);
      m_busy = 1'b0;
    end else begin
      check_val("rsp_done_idle", rsp_done, 0);
      check_val("rsp_err_idle", rsp_err, 0);
    end
    check_val("psel_excl", PSEL1 & PSEL2, 0);
    if (m_busy) begin
      setup = (cyc == m_acc + 1);
      check_val("ready_busy", req_ready, 0);
      check_val("psel1", PSEL1, !m_a[ADDR_W-1]);
      check_val("psel2", PSEL2, m_a[ADDR_W-1]);
      check_val("penable", PENABLE, !setup);
      check_val("pwrite", PWRITE, m_w);
      check_val("paddr", PADDR, m_a);
      check_val("pwdata", PWDATA, m_d);
    end else begin
      check_val("psel1_idle", PSEL1, 0);
      check_val("psel2_idle", PSEL2, 0);
      check_val("penable_idle", PENABLE, 0);
      check_val("pwrite_idle", PWRITE, 0);
      check_val("paddr_hold", PADDR, last_a);
      check_val("pwdata_hold", PWDATA, last_d);
      if (pend[0] && pend[1]) g = m_rr;
      else                    g = pend[1];
      if (pend[0] || pend[1]) begin
        check_val("req_ready", req_ready, 32'(2'b01 << g));
        m_busy = 1'b1;
        m_acc  = cyc;
        m_g    = g;
        m_rr   = !g;
        m_w    = pw[g];
        m_a    = pa[g];
        m_d    = pd[g];
        last_a = pa[g];
        last_d = pd[g];
        pend[g] = 1'b0;
        if (force_q.size() > 0) w = force_q.pop_front();
        else w = ($urandom_range(99) < 6) ? TIMEOUT : int'($urandom_range(4));
        m_to  = (w >= TIMEOUT);
        m_len = m_to ? TIMEOUT : w + 1;
      end else begin
        check_val("req_ready_none", req_ready, 0);
      end
    end
  endtask

  // One clock: drive requesters and slave just after the edge, check mid-cycle.
  task automatic step();
    @(posedge PCLK);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(99) < gen_pct[i]) new_cmd(i);
      else if (pend[i] && allow_drop && $urandom_range(99) < 3) pend[i] = 1'b0;
    end
    req_valid = {pend[1], pend[0]};
    req_write = {pw[1], pw[0]};
    req_addr  = {pa[1], pa[0]};
    req_wdata = {pd[1], pd[0]};
    PRDATA    = DATA_W'($urandom);
    if (m_busy && cyc >= m_acc + 2 && cyc < m_acc + 2 + m_len) begin
      PREADY = (!m_to && cyc == m_acc + 1 + m_len);
      if (PREADY) m_rd = m_w ? '0 : PRDATA;
    end else begin
      PREADY = 1'($urandom_range(1));
    end
    @(negedge PCLK);
    check_cycle();
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    gen_pct[0] = 0;
    gen_pct[1] = 0;
    while ((m_busy || pend[0] || pend[1]) && guard < 200) begin
      step();
      guard++;
    end
    check_val({tag, "_drained"}, guard < 200, 1);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_rr = 1'b0; last_a = '0; last_d = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    gen_pct[0] = 0; gen_pct[1] = 0;
    force_q.delete();
    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PRDATA = '0;
  endtask

  initial begin
    int guard;
    int start;
    allow_drop = 1'b0;
    PRESETn = 1'b0;
    model_reset();
    // Reset state, with both requesters asserting valid.
    repeat (2) @(negedge PCLK);
    req_valid = 2'b11;
    #1;
    check_all_zero("rst_init");
    req_valid = 2'b00;
    @(negedge PCLK);
    PRESETn = 1'b1;

    // T2: write to slave1, zero wait states.
    pend[0] = 1'b1; pw[0] = 1'b1; pa[0] = 9'h012; pd[0] = 8'hA5;
    force_q.push_back(0);
    step();
    check_val("t2_ready", req_ready, 2'b01);
    drain("t2");

    // T3: read from slave2 with three wait states.
    pend[1] = 1'b1; pw[1] = 1'b0; pa[1] = 9'h105; pd[1] = 8'h00;
    force_q.push_back(3);
    drain("t3");

    // T4: both requesters continuously valid -> strict alternation.
    start = dut_grants.size();
    gen_pct[0] = 100; gen_pct[1] = 100;
    guard = 0;
    while (dut_grants.size() < start + 6 && guard < 300) begin
      step();
      guard++;
    end
    check_val("t4_six_accepts", guard < 300, 1);
    for (int k = 0; k < 6; k++) begin
      if (start + k < dut_grants.size())
        check_val($sformatf("t4_grant%0d", k), dut_grants[start + k], k % 2);
    end
    drain("t4");

    // T5: timeout, followed by a normal transfer.
    force_q.push_back(TIMEOUT);
    force_q.push_back(0);
    pend[0] = 1'b1; pw[0] = 1'b0; pa[0] = 9'h033; pd[0] = 8'h11;
    step();
    pend[1] = 1'b1; pw[1] = 1'b1; pa[1] = 9'h1F0; pd[1] = 8'h5A;
    drain("t5");

    // T6: requester 0 always has another command ready.
    gen_pct[0] = 100; gen_pct[1] = 0;
    repeat (20) step();
    drain("t6");

    // Random traffic with withdrawals and timeouts.
    allow_drop = 1'b1;
    for (int r = 0; r < 1500; r++) begin
      if (r % 100 == 0) begin
        gen_pct[0] = $urandom_range(10, 90);
        gen_pct[1] = $urandom_range(10, 90);
      end
      step();
    end
    allow_drop = 1'b0;
    drain("rand");

    // T1: reset in the middle of ACCESS abandons the transfer.
    force_q.push_back(TIMEOUT);
    pend[1] = 1'b1; pw[1] = 1'b0; pa[1] = 9'h0FF; pd[1] = 8'h00;
    guard = 0;
    while (!(m_busy && cyc == m_acc + 5) && guard < 50) begin
      step();
      guard++;
    end
    check_val("t1_reach_access", guard < 50, 1);
    check_val("t1_in_access", PENABLE, 1);
    @(posedge PCLK);
    #2;
    PRESETn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    model_reset();
    repeat (2) @(negedge PCLK);
    check_all_zero("rst_hold");
    PRESETn = 1'b1;
    start = dut_grants.size();
    new_cmd(0);
    new_cmd(1);
    step();
    check_val("t1_grant_count", dut_grants.size(), start + 1);
    if (dut_grants.size() > start) check_val("t1_first_grant", dut_grants[start], 0);
    repeat (30) step();
    drain("t1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
